// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory, redirect and consumer handshakes.
// master = fetch unit side, slave = memory/execute side.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, prefetch FIFO of {pc, word}, redirect flush.
// Optional macro FETCH_BYPASS_EN forwards an ack straight to the consumer when the FIFO is empty.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;

    state_t        state_reg, state_next;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   addr_reg, addr_next;
    logic          req_reg;
    logic [CW-1:0] count_reg, count_next;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;

    logic [31:0] mem_instr [DEPTH];
    logic [31:0] mem_pc    [DEPTH];

    logic ack, head_valid, bypass, push, pop;

    // An ack only means something while a request is outstanding.
    assign ack        = req_reg & bus.imem_ack;
    assign head_valid = (count_reg != '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = !head_valid && (state_reg == WAIT) && bus.imem_ack &&
                    !bus.redirect && bus.instr_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = (state_reg == WAIT) && bus.imem_ack && !bus.redirect && !bypass;
    assign pop  = head_valid && bus.instr_ready && !bus.redirect;

    assign count_next = bus.redirect ? '0 : (count_reg + CW'(push) - CW'(pop));

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        if (bus.redirect) begin
            fetch_pc_next = bus.redirect_pc & ~32'h3;
            case (state_reg)
                IDLE:    state_next = WAIT;
                WAIT:    state_next = ack ? WAIT : KILL;
                KILL:    state_next = ack ? WAIT : KILL;
                default: state_next = IDLE;
            endcase
        end else begin
            case (state_reg)
                IDLE: if (count_reg < FULL) state_next = WAIT;
                WAIT: if (ack) begin
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                    state_next    = (count_next < FULL) ? WAIT : IDLE;
                end
                KILL: if (ack) state_next = WAIT;
                default: state_next = IDLE;
            endcase
        end
    end

    // The bus address is frozen while a request waits, even across a redirect (killed request).
    assign addr_next = (req_reg && !bus.imem_ack) ? addr_reg : fetch_pc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC & ~32'h3;
            addr_reg     <= RESET_PC & ~32'h3;
            req_reg      <= 1'b0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            addr_reg     <= addr_next;
            req_reg      <= (state_next != IDLE);
            count_reg    <= count_next;
            if (bus.redirect) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr_reg] <= bus.imem_rdata;
            mem_pc[wr_ptr_reg]    <= fetch_pc_reg;
        end
    end

    assign bus.imem_req  = req_reg;
    assign bus.imem_addr = addr_reg;

    always_comb begin
        bus.instr_valid = head_valid | bypass;
        bus.instr       = '0;
        bus.instr_pc    = '0;
        if (bypass) begin
            bus.instr    = bus.imem_rdata;
            bus.instr_pc = fetch_pc_reg;
        end else if (head_valid) begin
            bus.instr    = mem_instr[rd_ptr_reg];
            bus.instr_pc = mem_pc[rd_ptr_reg];
        end
    end
endmodule
